// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory bus between fetch and data ports.
// Ports: i_clk/i_rst (sync, active-high); f_* fetch request/ack;
//   d_* load/store request/ack; b_* registered bus request, b_rdata/b_ack
//   bus response. One bus transaction outstanding at a time.
// Build option: define MEM_ARB_FAIR_EN to bound data grants while fetch waits.
`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

module mem_arbiter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [`RW-1:0]     f_addr,
  input  logic               f_submit,
  output logic [`I_SIZE-1:0] f_data,
  output logic               f_ack,
  input  logic [`RW-1:0]     d_addr,
  input  logic [`RW-1:0]     d_wdata,
  input  logic               d_we,
  input  logic               d_submit,
  output logic [`RW-1:0]     d_data,
  output logic               d_ack,
  output logic [`RW-1:0]     b_addr,
  output logic [`RW-1:0]     b_wdata,
  output logic               b_we,
  output logic               b_instr,
  output logic               b_req,
  input  logic [`I_SIZE-1:0] b_rdata,
  input  logic               b_ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nx;

  logic           owner_d;
  logic           f_pend, d_pend;
  logic [`RW-1:0] f_slot_addr;
  logic [`RW-1:0] d_slot_addr;
  logic [`RW-1:0] d_slot_wdata;
  logic           d_slot_we;

  logic           f_avail, d_avail, issue_ok;
  logic           grant_f, grant_d, fair_fetch;
  logic [`RW-1:0] g_addr, g_wdata;
  logic           g_we;

  if (FAIR_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: FAIR_LIMIT must be >= 1");
  end

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(FAIR_LIMIT + 1);
  logic [CW-1:0] fair_cnt;

  assign fair_fetch = f_pend && (fair_cnt >= CW'(FAIR_LIMIT));

  always_ff @(posedge i_clk) begin
    if (i_rst)
      fair_cnt <= '0;
    else if (grant_f)
      fair_cnt <= '0;
    else if (grant_d && f_pend)
      fair_cnt <= fair_cnt + CW'(1);
  end
`else
  assign fair_fetch = 1'b0;
`endif

  // A new grant may go out in the ack cycle itself, so the bus sees
  // back-to-back transactions with no idle cycle in between.
  always_comb begin
    state_nx = state;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    f_avail  = f_pend | f_submit;
    d_avail  = d_pend | d_submit;
    issue_ok = (state == IDLE) || b_ack;
    f_ack    = 1'b0;
    d_ack    = 1'b0;
    g_addr   = '0;
    g_wdata  = '0;
    g_we     = 1'b0;

    if (state == BUSY && !i_rst) begin
      f_ack = b_ack & ~owner_d;
      d_ack = b_ack & owner_d;
    end
    if (state == BUSY && b_ack)
      state_nx = IDLE;

    if (issue_ok) begin
      if (f_avail && (fair_fetch || !d_avail))
        grant_f = 1'b1;
      else if (d_avail)
        grant_d = 1'b1;
    end
    if (grant_f || grant_d)
      state_nx = BUSY;

    unique case (1'b1)
      grant_d: begin
        g_addr  = d_pend ? d_slot_addr  : d_addr;
        g_wdata = d_pend ? d_slot_wdata : d_wdata;
        g_we    = d_pend ? d_slot_we    : d_we;
      end
      grant_f: g_addr = f_pend ? f_slot_addr : f_addr;
      default: ;
    endcase
  end

  assign f_data = b_rdata;
  assign d_data = b_rdata[`RW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b_req   <= 1'b0;
      b_we    <= 1'b0;
      b_instr <= 1'b0;
      owner_d <= 1'b0;
      f_pend  <= 1'b0;
      d_pend  <= 1'b0;
    end else begin
      b_req <= grant_f | grant_d;
      if (grant_f || grant_d) begin
        b_addr  <= g_addr;
        b_wdata <= g_wdata;
        b_we    <= g_we;
        b_instr <= grant_f;
        owner_d <= grant_d;
      end

      // A submit that is granted at once bypasses its slot.
      if (f_submit)
        f_slot_addr <= f_addr;
      if (grant_f)
        f_pend <= 1'b0;
      else if (f_submit)
        f_pend <= 1'b1;

      if (d_submit) begin
        d_slot_addr  <= d_addr;
        d_slot_wdata <= d_wdata;
        d_slot_we    <= d_we;
      end
      if (grant_d)
        d_pend <= 1'b0;
      else if (d_submit)
        d_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic for mem_arbiter,
// checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

module tb_mem_arbiter;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam int EXP_D_BEFORE_F = LIMIT;
`else
  localparam int EXP_D_BEFORE_F = 5;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [`RW-1:0]     f_addr, d_addr, d_wdata;
  logic               f_submit, d_submit, d_we;
  logic [`I_SIZE-1:0] f_data, b_rdata;
  logic [`RW-1:0]     d_data, b_addr, b_wdata;
  logic               f_ack, d_ack, b_we, b_instr, b_req, b_ack;

  mem_arbiter #(.FAIR_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .f_addr(f_addr), .f_submit(f_submit),
    .f_data(f_data), .f_ack(f_ack),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_we(d_we), .d_submit(d_submit),
    .d_data(d_data), .d_ack(d_ack),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_we(b_we), .b_instr(b_instr),
    .b_req(b_req), .b_rdata(b_rdata),
    .b_ack(b_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [`RW-1:0] addr;
    logic [`RW-1:0] wdata;
    logic           we;
  } req_t;

  req_t fq[$];
  req_t dq[$];
  bit   m_busy, m_own_d, m_after_rst;
  int   m_age, m_fair;
  bit   e_req, e_instr, e_we;
  logic [`RW-1:0] e_addr, e_wdata;

  int checks = 0;
  int errors = 0;
  bit obs_on = 0;
  int obs_d;
  bit obs_f;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit can_f(bit a);
    return fq.size() == 0 && (!(m_busy && !m_own_d) || a);
  endfunction

  function automatic bit can_d(bit a);
    return dq.size() == 0 && (!(m_busy && m_own_d) || a);
  endfunction

  task automatic tick(bit rst, bit fs, logic [`RW-1:0] fa,
                      bit ds, logic [`RW-1:0] da,
                      logic [`RW-1:0] dw, bit dwe,
                      bit ack, logic [`I_SIZE-1:0] rd);
    bit fp_old, free, gf, gd, fair_turn, ef, ed;
    req_t r;
    if (!fs) fa = 16'($urandom);
    if (!ds) begin
      da  = 16'($urandom);
      dw  = 16'($urandom);
      dwe = 1'($urandom);
    end
    i_rst = rst; f_submit = fs; f_addr = fa;
    d_submit = ds; d_addr = da; d_wdata = dw; d_we = dwe;
    b_ack = ack; b_rdata = rd;

    @(negedge i_clk);
    chk("b_req", b_req, e_req);
    if (e_req) begin
      chk("b_addr", b_addr, e_addr);
      chk("b_instr", b_instr, e_instr);
      chk("b_we", b_we, e_we);
      if (e_we) chk("b_wdata", b_wdata, e_wdata);
    end
    if (m_after_rst) begin
      chk("rst_b_we", b_we, 0);
      chk("rst_b_instr", b_instr, 0);
      m_after_rst = 0;
    end
    ef = !rst && ack && m_busy && !m_own_d;
    ed = !rst && ack && m_busy && m_own_d;
    chk("f_ack", f_ack, ef);
    chk("d_ack", d_ack, ed);
    if (ef) chk("f_data", f_data, rd);
    if (ed) chk("d_data", d_data, rd[`RW-1:0]);
    if (obs_on && b_req) begin
      if (b_instr) obs_f = 1;
      else if (!obs_f) obs_d++;
    end

    if (rst) begin
      fq.delete(); dq.delete();
      m_busy = 0; m_fair = 0; m_age = 0;
      e_req = 0; m_after_rst = 1;
    end else begin
      fp_old = fq.size() > 0;
      free   = !m_busy || ack;
      if (m_busy && ack) m_busy = 0;
      if (fs) fq.push_back('{addr: fa, wdata: '0, we: 1'b0});
      if (ds) dq.push_back('{addr: da, wdata: dw, we: dwe});
      fair_turn = 0;
`ifdef MEM_ARB_FAIR_EN
      fair_turn = fp_old && m_fair >= LIMIT;
`endif
      gf = 0; gd = 0;
      if (free) begin
        if (fair_turn && fq.size() > 0) gf = 1;
        else if (dq.size() > 0) gd = 1;
        else if (fq.size() > 0) gf = 1;
      end
      e_req = gf || gd;
      if (gd) begin
        r = dq.pop_front();
        e_addr = r.addr; e_wdata = r.wdata; e_we = r.we;
        e_instr = 0; m_own_d = 1;
        if (fp_old) m_fair++;
      end
      if (gf) begin
        r = fq.pop_front();
        e_addr = r.addr; e_we = 0; e_instr = 1;
        m_own_d = 0; m_fair = 0;
      end
      if (e_req) begin
        m_busy = 1; m_age = 0;
      end else if (m_busy) begin
        m_age++;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(bit ack, logic [`I_SIZE-1:0] rd);
    tick(0, 0, '0, 0, '0, '0, 0, ack, rd);
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++)
      idle(m_busy && m_age >= 1, $urandom);
  endtask

  initial begin
    bit a, fs, ds, rs;
    int nsub;
    i_rst = 1; f_submit = 0; d_submit = 0; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    b_ack = 0; b_rdata = '0;
    e_req = 0; m_busy = 0; m_own_d = 0;
    m_age = 0; m_fair = 0; m_after_rst = 0;
    @(posedge i_clk);
    #1;

    // reset held while the bus pulses ack, then one cycle after
    tick(1, 0, '0, 0, '0, '0, 0, 1, 32'hdead0001);
    tick(1, 0, '0, 0, '0, '0, 0, 1, 32'hdead0002);
    idle(1, 32'hdead0003);

    // single fetch, ack two cycles after the request
    tick(0, 1, 16'h0010, 0, '0, '0, 0, 0, '0);
    idle(0, '0);
    idle(0, '0);
    idle(1, 32'h12345678);
    drain(3);

    // simultaneous fetch and load: data first
    tick(0, 1, 16'h0020, 1, 16'h8000, '0, 0, 0, '0);
    idle(0, '0);
    idle(1, 32'hcafe8000);
    idle(0, '0);
    idle(1, 32'h00c0ffee);
    drain(3);

    // store
    tick(0, 0, '0, 1, 16'h0100, 16'hBEEF, 1, 0, '0);
    idle(0, '0);
    idle(1, 32'h5a5a5a5a);
    drain(3);

    // fetch resubmits in its own ack cycle while a load waits
    tick(0, 1, 16'h0010, 0, '0, '0, 0, 0, '0);
    tick(0, 0, '0, 1, 16'h0200, '0, 0, 0, '0);
    tick(0, 1, 16'h0011, 0, '0, '0, 0, 1, 32'h11110010);
    idle(0, '0);
    idle(1, 32'h22220200);
    idle(0, '0);
    idle(1, 32'h33330011);
    drain(3);

    // back-to-back data traffic with a fetch waiting
    tick(0, 0, '0, 1, 16'h0500, '0, 0, 0, '0);
    obs_on = 1; obs_d = 0; obs_f = 0;
    tick(0, 1, 16'h0040, 0, '0, '0, 0, 0, '0);
    obs_d = 0;
    nsub = 0;
    for (int i = 0; i < 40 && !obs_f; i++) begin
      a  = m_busy && m_age >= 1;
      ds = a && m_own_d && nsub < 5;
      if (ds) nsub++;
      tick(0, 0, '0, ds, 16'(16'h0600 + i), '0, 0,
           a, $urandom);
    end
    obs_on = 0;
    chk("fetch_granted", obs_f, 1);
    chk("data_grants_before_fetch", obs_d, EXP_D_BEFORE_F);
    drain(12);

    // random traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      a  = m_busy && m_age >= 1 && ($urandom_range(0, 2) != 0);
      fs = can_f(a) && ($urandom_range(0, 1) == 1);
      ds = can_d(a) && ($urandom_range(0, 2) != 0);
      tick(rs, fs, 16'($urandom), ds, 16'($urandom),
           16'($urandom), 1'($urandom_range(0, 1)),
           a, $urandom);
    end
    drain(12);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
